// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field positions, EXT prefix match,
// ALU operation encoding and prefix FSM states.
package decode_pkg;

  localparam int BIT_YSEL = 12;
  localparam int BIT_U    = 10;
  localparam int OP_HI    = 9;
  localparam int OP_LO    = 8;
  localparam int BIT_ZX   = 7;
  localparam int BIT_SW   = 6;
  localparam int DST_HI   = 5;
  localparam int DST_LO   = 3;
  localparam int COND_HI  = 2;
  localparam int COND_LO  = 0;

  localparam int EXT_HI = 14;
  localparam int EXT_LO = 13;
  localparam logic [1:0] EXT_MATCH = 2'b01;
  localparam int PAYLOAD_W = 13;

  localparam logic [2:0] DST_IMM = 3'b100;

  // {u, op}: upper half is arithmetic, lower half is logic
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOT = 3'b011,
    ALU_ADD = 3'b100,
    ALU_INC = 3'b101,
    ALU_SUB = 3'b110,
    ALU_DEC = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/exec_unit.sv
// Combinational ALU and jump condition for compute instructions.
module exec_unit
  import decode_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             y_sel,
  input  alu_op_e          alu_op,
  input  logic             zx,
  input  logic             sw,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] a_mem,
  output logic [WIDTH-1:0] result,
  output logic             jmp
);

  logic [WIDTH-1:0] y_raw;
  logic [WIDTH-1:0] x_sw;
  logic [WIDTH-1:0] y_sw;
  logic [WIDTH-1:0] x;
  logic             is_neg;
  logic             is_zero;

  assign y_raw = y_sel ? a_mem : a;
  assign x_sw  = sw ? y_raw : d;
  assign y_sw  = sw ? d : y_raw;
  assign x     = zx ? '0 : x_sw;

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND: result = x & y_sw;
      ALU_OR:  result = x | y_sw;
      ALU_XOR: result = x ^ y_sw;
      ALU_NOT: result = ~x;
      ALU_ADD: result = x + y_sw;
      ALU_INC: result = x + WIDTH'(1);
      ALU_SUB: result = x - y_sw;
      ALU_DEC: result = x - WIDTH'(1);
      default: result = '0;
    endcase
  end

  // cond is {lt, eq, gt}; result is read as two's complement
  assign is_neg  = result[WIDTH-1];
  assign is_zero = (result == '0);
  assign jmp     = (cond[2] && is_neg) || (cond[1] && is_zero) ||
                   (cond[0] && !is_neg && !is_zero);

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode/execute stage with valid/ready handshake and an
// optional EXT prefix that supplies the top bit of a following immediate.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit PREFIX_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] d_reg,
  input  logic [WIDTH-1:0] a_mem_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       dst,
  output logic             jmp,
  output logic             ext_drop
);

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_reg;
  logic [2:0]           dst_reg;
  logic                 jmp_reg;
  logic                 ext_drop_reg;
  logic [PAYLOAD_W-1:0] ext_payload_reg;
  state_e               state_reg;

  logic             accept;
  logic             is_imm;
  logic             is_ext;
  logic             pending;
  logic [WIDTH-1:0] payload_wide;
  logic [WIDTH-1:0] imm_value;
  logic [WIDTH-1:0] alu_result;
  logic             alu_jmp;
  logic [WIDTH-1:0] out_next;
  logic [2:0]       dst_next;
  logic             jmp_next;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign pending  = (state_reg == ST_PENDING);

  assign is_imm = !instruction[WIDTH-1];
  assign is_ext = PREFIX_EN && instruction[WIDTH-1] &&
                  (instruction[EXT_HI:EXT_LO] == EXT_MATCH);

  // Only the payload LSB survives the shift into the top bit after truncation
  assign payload_wide = {{(WIDTH-PAYLOAD_W){1'b0}}, ext_payload_reg};
  assign imm_value    = pending ? ((payload_wide << (WIDTH-1)) |
                                   {1'b0, instruction[WIDTH-2:0]})
                                : instruction;

  exec_unit #(
    .WIDTH (WIDTH)
  ) u_exec (
    .y_sel  (instruction[BIT_YSEL]),
    .alu_op (alu_op_e'({instruction[BIT_U], instruction[OP_HI:OP_LO]})),
    .zx     (instruction[BIT_ZX]),
    .sw     (instruction[BIT_SW]),
    .cond   (instruction[COND_HI:COND_LO]),
    .a      (a_reg),
    .d      (d_reg),
    .a_mem  (a_mem_reg),
    .result (alu_result),
    .jmp    (alu_jmp)
  );

  assign out_next = is_imm ? imm_value : alu_result;
  assign dst_next = is_imm ? DST_IMM : instruction[DST_HI:DST_LO];
  assign jmp_next = is_imm ? 1'b0 : alu_jmp;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_reg         <= '0;
      dst_reg         <= '0;
      jmp_reg         <= 1'b0;
      ext_drop_reg    <= 1'b0;
      ext_payload_reg <= '0;
      state_reg       <= ST_IDLE;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      ext_drop_reg  <= 1'b0;
      state_reg     <= ST_IDLE;
    end else begin
      ext_drop_reg <= accept && !is_imm && !is_ext && pending;

      if (accept && !is_ext) begin
        out_valid_reg <= 1'b1;
        out_reg       <= out_next;
        dst_reg       <= dst_next;
        jmp_reg       <= jmp_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      // An EXT never produces a beat; it only arms the prefix
      if (accept) begin
        if (is_ext) begin
          state_reg       <= ST_PENDING;
          ext_payload_reg <= instruction[PAYLOAD_W-1:0];
        end else begin
          state_reg <= ST_IDLE;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign dst       = dst_reg;
  assign jmp       = jmp_reg;
  assign ext_drop  = ext_drop_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage (WIDTH=16) against a
// behavioural model of the instruction set and handshake.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [15:0] a_mem_reg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  dst;
  logic        jmp;
  logic        ext_drop;

  int compares   = 0;
  int mismatches = 0;
  int beat_no    = 0;

  // model state
  bit          m_valid;
  logic [15:0] m_out;
  logic [2:0]  m_dst;
  bit          m_jmp;
  bit          m_drop;
  bit          m_pend;
  logic [12:0] m_pay;

  always #5 clk = ~clk;

  decode_stage #(
    .WIDTH     (16),
    .PREFIX_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .a_reg       (a_reg),
    .d_reg       (d_reg),
    .a_mem_reg   (a_mem_reg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .dst         (dst),
    .jmp         (jmp),
    .ext_drop    (ext_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics in plain integer arithmetic
  function automatic void ref_beat(input logic [15:0] ins, input logic [15:0] a,
                                   input logic [15:0] d, input logic [15:0] am,
                                   input bit pend, input logic [12:0] pay,
                                   output logic [15:0] res, output logic [2:0] ds,
                                   output bit j);
    int x, y, t, r, s;
    if (!ins[15]) begin
      r  = pend ? (int'(pay[0]) * 32768 + int'(ins[14:0])) : int'(ins);
      ds = 3'b100;
      j  = 1'b0;
    end else begin
      y = ins[12] ? int'(am) : int'(a);
      x = int'(d);
      if (ins[6]) begin t = x; x = y; y = t; end
      if (ins[7]) x = 0;
      case ({ins[10], ins[9:8]})
        3'd0:    r = x & y;
        3'd1:    r = x | y;
        3'd2:    r = x ^ y;
        3'd3:    r = 65535 - x;
        3'd4:    r = (x + y) % 65536;
        3'd5:    r = (x + 1) % 65536;
        3'd6:    r = (x - y + 65536) % 65536;
        default: r = (x + 65535) % 65536;
      endcase
      s  = (r >= 32768) ? r - 65536 : r;
      j  = (ins[2] && s < 0) || (ins[1] && s == 0) || (ins[0] && s > 0);
      ds = ins[5:3];
    end
    res = 16'(r);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 0; m_out = '0; m_dst = '0; m_jmp = 0; m_drop = 0; m_pend = 0; m_pay = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_dst", dst, 0);
    check("rst_jmp", jmp, 0);
    check("rst_ext_drop", ext_drop, 0);
    $display("reset applied");
  endtask

  // One clock: drive inputs, check the present state against the model,
  // then advance the model as the clock edge does.
  task automatic do_cycle(input bit v, input logic [15:0] ins, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] am,
                          input bit ordy, input bit fl);
    bit          acc, is_imm, is_ext, j;
    logic [15:0] r;
    logic [2:0]  ds;
    in_valid = v; instruction = ins; a_reg = a; d_reg = d; a_mem_reg = am;
    out_ready = ordy; flush = fl;
    #1;
    check("in_ready", in_ready, !m_valid || ordy);
    check("out_valid", out_valid, m_valid);
    check("ext_drop", ext_drop, m_drop);
    if (m_valid) begin
      check("out", out, m_out);
      check("dst", dst, m_dst);
      check("jmp", jmp, m_jmp);
      if (ordy) begin
        $display("beat %0d: out=%h dst=%b jmp=%0b", beat_no, out, dst, jmp);
        beat_no++;
      end
    end
    acc    = v && (!m_valid || ordy) && !fl;
    is_imm = !ins[15];
    is_ext = ins[15] && (ins[14:13] == 2'b01);
    if (fl) begin
      m_valid = 0; m_drop = 0; m_pend = 0;
    end else begin
      m_drop = acc && !is_imm && !is_ext && m_pend;
      if (acc && !is_ext) begin
        ref_beat(ins, a, d, am, m_pend, m_pay, r, ds, j);
        m_valid = 1; m_out = r; m_dst = ds; m_jmp = j;
      end else if (ordy) begin
        m_valid = 0;
      end
      if (acc) begin
        if (is_ext) begin m_pend = 1; m_pay = ins[12:0]; end
        else m_pend = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 0; in_valid = 0; instruction = '0;
    a_reg = '0; d_reg = '0; a_mem_reg = '0; out_ready = 0;
    @(negedge clk);
    do_reset();

    // immediate, latency 1
    do_cycle(1, 16'h1234, 0, 0, 0, 1, 0);
    check("imm_out", out, 16'h1234);
    check("imm_dst", dst, 3'b100);
    check("imm_jmp", jmp, 0);
    check("imm_valid", out_valid, 1);

    // D+A = -1 with all conditions set
    do_cycle(1, 16'hE417, 16'hFFFA, 16'h0005, 16'h0000, 1, 0);
    check("add_out", out, 16'hFFFF);
    check("add_dst", dst, 3'b010);
    check("add_jmp", jmp, 1);

    // EXT payload 1 then immediate 5
    do_cycle(1, 16'hA001, 0, 0, 0, 1, 0);
    check("ext_nobeat", out_valid, 0);
    do_cycle(1, 16'h0005, 0, 0, 0, 1, 0);
    check("ext_imm_out", out, 16'h8005);
    check("ext_imm_valid", out_valid, 1);
    do_cycle(0, 16'h0000, 0, 0, 0, 1, 0);
    check("ext_single_beat", out_valid, 0);

    // EXT dropped by compute D-1 with D=0
    do_cycle(1, 16'hA003, 0, 0, 0, 1, 0);
    do_cycle(1, 16'hE710, 16'h1111, 16'h0000, 16'h2222, 1, 0);
    check("drop_pulse", ext_drop, 1);
    check("drop_out", out, 16'hFFFF);
    do_cycle(0, 16'h0000, 0, 0, 0, 1, 0);
    check("drop_low", ext_drop, 0);

    // stall three cycles with inputs offered back-to-back
    do_cycle(1, 16'h0111, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 16'h0222, 0, 0, 0, 0, 0);
      check("stall_hold", out, 16'h0111);
      check("stall_ready", in_ready, 0);
    end
    do_cycle(1, 16'h0222, 0, 0, 0, 1, 0);
    check("stall_next", out, 16'h0222);
    do_cycle(0, 16'h0000, 0, 0, 0, 1, 0);

    // flush with EXT pending and consumer stalled
    do_cycle(1, 16'hA001, 0, 0, 0, 1, 0);
    do_cycle(1, 16'h0444, 0, 0, 0, 0, 1);
    check("flush_valid", out_valid, 0);
    do_cycle(1, 16'h0005, 0, 0, 0, 1, 0);
    check("flush_imm", out, 16'h0005);

    // flush of a stalled beat
    do_cycle(1, 16'h0101, 0, 0, 0, 0, 0);
    do_cycle(1, 16'h0202, 0, 0, 0, 0, 1);
    check("flush_stalled", out_valid, 0);

    // reset abandons a pending prefix
    do_cycle(1, 16'hA001, 0, 0, 0, 1, 0);
    do_reset();
    do_cycle(1, 16'h0005, 0, 0, 0, 1, 0);
    check("rst_prefix_gone", out, 16'h0005);
    do_cycle(1, 16'h0606, 0, 0, 0, 0, 0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else do_cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    do_cycle(0, 16'h0000, 0, 0, 0, 1, 0);
    do_cycle(0, 16'h0000, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
